// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered add/sub/and/xor ALU among NUM_REQ requesters.
// Optional condition-code generation is enabled by defining ALU_CC_EN.
module alu_share_arbiter #(
    parameter int W       = 64,
    parameter int NUM_REQ = 2,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [W*NUM_REQ-1:0]   req_a,
    input  logic [W*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [W-1:0]           rsp_data,
    output logic [2:0]             rsp_cc,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [2:0]     rsp_cc_q, rsp_cc_d;

    logic [1:0]     op_arr [NUM_REQ];
    logic [W-1:0]   a_arr  [NUM_REQ];
    logic [W-1:0]   b_arr  [NUM_REQ];

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic [W-1:0]   alu_r;
    logic [2:0]     cc_calc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]    = req_op[2*gi +: 2];
            assign a_arr[gi]     = req_a[W*gi +: W];
            assign b_arr[gi]     = req_b[W*gi +: W];
            // Gated by rst_n so nothing is accepted while reset is held.
            assign req_ready[gi] = rst_n && (state_q == IDLE) && grant_found &&
                                   (grant_idx == IDW'(gi));
        end
    endgenerate

    // Scan starting one past the last winner, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && cand == IDW'(i) && req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        alu_r = a_q + b_q;
        case (op_q)
            2'd0:    alu_r = a_q + b_q;
            2'd1:    alu_r = a_q - b_q;
            2'd2:    alu_r = a_q & b_q;
            default: alu_r = a_q ^ b_q;
        endcase
    end

`ifdef ALU_CC_EN
    logic of_flag;
    always_comb begin
        of_flag = 1'b0;
        case (op_q)
            2'd0:    of_flag = (a_q[W-1] == b_q[W-1]) && (alu_r[W-1] != a_q[W-1]);
            2'd1:    of_flag = (a_q[W-1] != b_q[W-1]) && (alu_r[W-1] != a_q[W-1]);
            default: of_flag = 1'b0;
        endcase
        cc_calc = {(alu_r == '0), alu_r[W-1], of_flag};
    end
`else
    assign cc_calc = 3'b000;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        rsp_id_d   = rsp_id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_cc_d   = rsp_cc_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx == IDW'(i)) begin
                            op_d = op_arr[i];
                            a_d  = a_arr[i];
                            b_d  = b_arr[i];
                        end
                    end
                    owner_d  = grant_idx;
                    rr_ptr_d = grant_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_r;
                rsp_cc_d   = cc_calc;
                rsp_id_d   = owner_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDW'(NUM_REQ - 1);
            owner_q    <= '0;
            rsp_id_q   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_cc_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rsp_id_q   <= rsp_id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_cc_q   <= rsp_cc_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cc    = rsp_cc_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NUM_REQ=2, W=64); one task per scenario.
module tb_alu_share_arbiter;

`ifdef ALU_CC_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [3:0]   req_op = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic [2:0]   rsp_cc;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter #(.W(64), .NUM_REQ(2), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cc(rsp_cc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input int i, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op[2*i +: 2] = op;
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, busy} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctl: ready=%b valid=%b busy=%b, want 0", req_ready, rsp_valid, busy);
        end
        n_cmp++;
        if ({rsp_id, rsp_cc} !== 5'b0 || rsp_data !== 64'd0) begin
            n_err++; $display("FAIL reset_rsp: id=%0d cc=%b data=%h, want 0", rsp_id, rsp_cc, rsp_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_single_sub;
        @(negedge clk);
        drive(0, 2'd1, 64'd1, 64'd3);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL sub_ready: got %b want 01", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
            n_err++; $display("FAIL sub_exec: valid=%b busy=%b ready=%b want 0/1/00", rsp_valid, busy, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL sub_latency: rsp_valid=%b want 1 two edges after accept", rsp_valid);
        end
        n_cmp++;
        if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFE || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL sub_data: data=%h id=%0d want FFFFFFFFFFFFFFFE id 0", rsp_data, rsp_id);
        end
        n_cmp++;
        if (rsp_cc !== (CC_ON ? 3'b010 : 3'b000)) begin
            n_err++; $display("FAIL sub_cc: got %b want %b", rsp_cc, CC_ON ? 3'b010 : 3'b000);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL sub_release: valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
        $display("single sub: 1-3 data=%h id=%0d cc=%b", 64'hFFFF_FFFF_FFFF_FFFE, 0, rsp_cc);
    endtask

    task automatic test_overflow_add;
        bit ok;
        @(negedge clk);
        drive(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL add_ready: got %b want 10", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL add_timeout: rsp_valid never rose");
        end
        n_cmp++;
        if (rsp_data !== 64'h8000_0000_0000_0000 || rsp_id !== 2'd1) begin
            n_err++; $display("FAIL add_data: data=%h id=%0d want 8000000000000000 id 1", rsp_data, rsp_id);
        end
        n_cmp++;
        if (rsp_cc !== (CC_ON ? 3'b011 : 3'b000)) begin
            n_err++; $display("FAIL add_cc: got %b want %b", rsp_cc, CC_ON ? 3'b011 : 3'b000);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("overflow add: data=%h id=%0d cc=%b", rsp_data, rsp_id, rsp_cc);
    endtask

    task automatic test_contention;
        int grants[$];
        int n_rsp = 0;
        int pulses0 = 0;
        int pulses1 = 0;
        logic [63:0] exp_data;
        @(negedge clk);
        drive(0, 2'd0, 64'd10, 64'd20);
        drive(1, 2'd1, 64'd100, 64'd1);
        rsp_ready = 1'b1;
        for (int t = 0; t < 40 && n_rsp < 4; t++) begin
            #1;
            if (req_ready === 2'b01) begin grants.push_back(0); pulses0++; end
            else if (req_ready === 2'b10) begin grants.push_back(1); pulses1++; end
            else if (req_ready !== 2'b00) begin
                n_cmp++; n_err++; $display("FAIL cont_onehot: ready=%b", req_ready);
            end
            if (rsp_valid === 1'b1) begin
                exp_data = (n_rsp % 2 == 0) ? 64'd30 : 64'd99;
                n_cmp++;
                if (rsp_id !== 2'(n_rsp % 2) || rsp_data !== exp_data) begin
                    n_err++; $display("FAIL cont_rsp%0d: id=%0d data=%0d want id %0d data %0d",
                                      n_rsp, rsp_id, rsp_data, n_rsp % 2, exp_data);
                end
                $display("contention op %0d: id=%0d data=%0d", n_rsp, rsp_id, rsp_data);
                n_rsp++;
            end
            if (n_rsp == 4) req_valid = '0;
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        n_cmp++;
        if (n_rsp != 4 || grants.size() != 4) begin
            n_err++; $display("FAIL cont_count: rsp=%0d grants=%0d want 4/4", n_rsp, grants.size());
        end else begin
            n_cmp++;
            if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
                n_err++; $display("FAIL cont_order: got %0d%0d%0d%0d want 0101",
                                  grants[0], grants[1], grants[2], grants[3]);
            end
        end
        n_cmp++;
        if (pulses0 != 2 || pulses1 != 2) begin
            n_err++; $display("FAIL cont_pulses: req0=%0d req1=%0d want 2/2", pulses0, pulses1);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        @(negedge clk);
        drive(0, 2'd3, 64'h5A5A, 64'h5A5A);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL bp_timeout: rsp_valid never rose");
        end
        drive(1, 2'd0, 64'd5, 64'd6);
        for (int t = 0; t < 5; t++) begin
            #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'd0 || rsp_id !== 2'd0 || req_ready !== 2'b00) begin
                n_err++; $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d ready=%b want 1/0/0/00",
                                  t, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rsp_cc !== (CC_ON ? 3'b100 : 3'b000)) begin
            n_err++; $display("FAIL bp_cc: got %b want %b", rsp_cc, CC_ON ? 3'b100 : 3'b000);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_release: valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
        $display("backpressure: xor 5A5A^5A5A held 5 cycles, cc=%b", rsp_cc);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen = 1'b0;
        @(negedge clk);
        drive(0, 2'd0, 64'd1, 64'd1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_exec: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_async: busy=%b valid=%b want 0/0", busy, rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL mid_norsp: rsp_valid pulsed after reset, want none");
        end
        drive(1, 2'd2, 64'hF0F0, 64'hFF00);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL mid_ready: got %b want 10", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd1 || rsp_data !== 64'hF000 || rsp_cc !== 3'b000) begin
            n_err++; $display("FAIL mid_op: ok=%b id=%0d data=%h cc=%b want 1/1/F000/000",
                              ok, rsp_id, rsp_data, rsp_cc);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("reset mid-op: follow-up and id=%0d data=%h", rsp_id, rsp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_sub();
        test_overflow_add();
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
